// File: rtl/lsu_uncached_sb_if.sv
// Bus structs and the pipeline/bus bundle of the uncached LSU; slave = LSU side, master = environment side.
package lsu_uncached_sb_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic        burst;
        logic        cached;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  data_strobe;
        logic        data_ok;
        logic        data_last;
    } cache_bus_req_t;

    typedef struct packed {
        logic        ready;
        logic        data_ok;
        logic        data_last;
        logic [31:0] r_data;
    } cache_bus_resp_t;
endpackage

interface lsu_uncached_sb_if #(parameter int LANES = 2);
    import lsu_uncached_sb_pkg::*;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]    req_valid;
    logic [LANES-1:0]    req_write;
    logic [LANES*2-1:0]  req_type;
    logic [LANES-1:0]    req_signed;
    logic [LANES*32-1:0] req_addr;
    logic [LANES*32-1:0] req_wdata;
    logic [LANES-1:0]    req_ready;
    logic                resp_valid;
    logic [LW-1:0]       resp_lane;
    logic [31:0]         resp_data;
    logic                sb_empty;
    cache_bus_req_t      bus_req;
    cache_bus_resp_t     bus_resp;

    modport slave (
        input  req_valid, req_write, req_type, req_signed, req_addr, req_wdata, bus_resp,
        output req_ready, resp_valid, resp_lane, resp_data, sb_empty, bus_req
    );
    modport master (
        output req_valid, req_write, req_type, req_signed, req_addr, req_wdata, bus_resp,
        input  req_ready, resp_valid, resp_lane, resp_data, sb_empty, bus_req
    );
endinterface

// File: rtl/lsu_uncached_sb.sv
// Uncached LSU: lane arbiter, FIFO store buffer, single outstanding load; stores post on accept, loads answer 1 cycle after bus data.
// Backpressure via one-hot req_ready (SB full / load busy); LSU_STORE_FORWARD_EN adds full-cover store-to-load forwarding.
module lsu_uncached_sb
    import lsu_uncached_sb_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int SB_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    lsu_uncached_sb_if.slave lsu
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [29:0]   sb_addr [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [3:0]    sb_strb [SB_DEPTH];

    logic          load_pend, ld_signed;
    logic [31:0]   ld_addr;
    logic [1:0]    ld_type;
    logic [LW-1:0] ld_lane;

    logic [LW-1:0] win;
    logic          any, w_write, w_signed, w_misalign;
    logic [1:0]    w_type, w_off;
    logic [31:0]   w_addr, w_wdata;
    logic [3:0]    w_strb;
    logic          load_ok, acc_ok, push, pop, ld_acc, rd_done;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] ty, input logic sg);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (ty)
            2'b00:   return {{24{sg & s[7]}}, s[7:0]};
            2'b01:   return {{16{sg & s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Lowest index wins: scan downwards so lane 0 overrides.
    always_comb begin
        win = '0; any = 1'b0; w_write = 1'b0; w_signed = 1'b0;
        w_type = 2'b00; w_addr = '0; w_wdata = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lsu.req_valid[i]) begin
                win      = LW'(i);
                any      = 1'b1;
                w_write  = lsu.req_write[i];
                w_signed = lsu.req_signed[i];
                w_type   = lsu.req_type[i*2 +: 2];
                w_addr   = lsu.req_addr[i*32 +: 32];
                w_wdata  = lsu.req_wdata[i*32 +: 32];
            end
        end
        case (w_type)
            2'b00:   begin w_off = w_addr[1:0];        w_strb = 4'b0001 << w_addr[1:0]; end
            2'b01:   begin w_off = {w_addr[1], 1'b0};  w_strb = 4'b0011 << {w_addr[1], 1'b0}; end
            default: begin w_off = 2'b00;              w_strb = 4'b1111; end
        endcase
        w_misalign = ((w_type == 2'b01) && w_addr[0]) || (w_type[1] && (w_addr[1:0] != 2'b00));
    end

`ifdef LSU_STORE_FORWARD_EN
    logic          fwd_found;
    logic [31:0]   fwd_word;
    logic [3:0]    fwd_strb;
    logic [PW-1:0] idx;
    // Walk oldest to newest so the last match left standing is the newest entry.
    always_comb begin
        fwd_found = 1'b0; fwd_word = '0; fwd_strb = '0; idx = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (sb_addr[idx] == w_addr[31:2])) begin
                fwd_found = 1'b1;
                fwd_word  = sb_data[idx];
                fwd_strb  = sb_strb[idx];
            end
        end
        fwd_hit  = fwd_found && ((fwd_strb & w_strb) == w_strb);
        fwd_data = ext(fwd_word, w_off, w_type, w_signed);
    end
    assign load_ok = !load_pend;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign load_ok  = !load_pend && (count == '0);
`endif

    assign acc_ok        = any && !rst && (w_write ? (count != (PW+1)'(SB_DEPTH)) : load_ok);
    assign lsu.req_ready = acc_ok ? (LANES'(1) << win) : '0;
    assign push          = acc_ok && w_write;
    assign ld_acc        = acc_ok && !w_write;
    assign pop           = (state == DATA) && lsu.bus_req.write && lsu.bus_resp.data_ok;
    assign rd_done       = (state == DATA) && !lsu.bus_req.write && lsu.bus_resp.data_ok
                           && lsu.bus_resp.data_last;
    assign lsu.sb_empty  = (count == '0) && (state == IDLE) && !load_pend;

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= w_addr[31:2];
            sb_data[wr_ptr] <= w_wdata << {w_off, 3'b000};
            sb_strb[wr_ptr] <= w_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE; wr_ptr <= '0; rd_ptr <= '0; count <= '0;
            load_pend <= 1'b0; ld_addr <= '0; ld_type <= '0; ld_signed <= 1'b0; ld_lane <= '0;
            lsu.resp_valid <= 1'b0; lsu.resp_lane <= '0; lsu.resp_data <= '0;
            lsu.bus_req <= '0;
        end else begin
            lsu.resp_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);

            if (rd_done) begin
                load_pend <= 1'b0;
            end else if (ld_acc && fwd_hit) begin
                lsu.resp_valid <= 1'b1;
                lsu.resp_data  <= fwd_data;
                lsu.resp_lane  <= win;
            end else if (ld_acc) begin
                load_pend <= 1'b1;
                ld_addr   <= {w_addr[31:2], w_off};
                ld_type   <= w_type;
                ld_signed <= w_signed;
                ld_lane   <= win;
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        lsu.bus_req.valid       <= 1'b1;
                        lsu.bus_req.write       <= 1'b1;
                        lsu.bus_req.addr        <= {sb_addr[rd_ptr], 2'b00};
                        lsu.bus_req.w_data      <= sb_data[rd_ptr];
                        lsu.bus_req.data_strobe <= sb_strb[rd_ptr];
                        state <= ADDR;
                    end else if (load_pend) begin
                        lsu.bus_req.valid       <= 1'b1;
                        lsu.bus_req.write       <= 1'b0;
                        lsu.bus_req.addr        <= {ld_addr[31:2], 2'b00};
                        lsu.bus_req.w_data      <= '0;
                        lsu.bus_req.data_strobe <= '0;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (lsu.bus_resp.ready) begin
                        lsu.bus_req.valid     <= 1'b0;
                        lsu.bus_req.data_ok   <= 1'b1;
                        lsu.bus_req.data_last <= 1'b1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (pop || rd_done) begin
                        lsu.bus_req.data_ok   <= 1'b0;
                        lsu.bus_req.data_last <= 1'b0;
                        state <= IDLE;
                    end
                    if (rd_done) begin
                        lsu.resp_valid <= 1'b1;
                        lsu.resp_data  <= ext(lsu.bus_resp.r_data, ld_addr[1:0], ld_type, ld_signed);
                        lsu.resp_lane  <= ld_lane;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Misaligned half/word is a pipeline bug; hardware still forces alignment above.
    a_aligned: assert property (@(posedge clk) disable iff (rst) !(acc_ok && w_misalign));
endmodule

// File: tb/tb_lsu_uncached_sb.sv
// Scoreboard bench for lsu_uncached_sb: expected bus ops and load responses are queued at issue, a monitor pops them.
module tb_lsu_uncached_sb;
    import lsu_uncached_sb_pkg::*;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } bus_exp_t;
    typedef struct {
        int          lane;
        logic [31:0] data;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic addr_en, data_en;
    logic [31:0] rd_word;
    int n_checks = 0;
    int n_fail = 0;
    int n_reads = 0;
    bus_exp_t  exp_bus[$];
    resp_exp_t exp_resp[$];

    lsu_uncached_sb_if #(.LANES(2)) ifc ();
    lsu_uncached_sb #(.LANES(2), .SB_DEPTH(4)) dut (.clk(clk), .rst(rst), .lsu(ifc.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus slave: responds from registered DUT outputs, updated well after the edge.
    initial begin
        ifc.bus_resp = '0;
        forever begin
            @(posedge clk);
            #2;
            ifc.bus_resp.ready     = addr_en && ifc.bus_req.valid;
            ifc.bus_resp.data_ok   = data_en && ifc.bus_req.data_ok;
            ifc.bus_resp.data_last = data_en && ifc.bus_req.data_ok;
            ifc.bus_resp.r_data    = rd_word;
        end
    end

    // Monitor: address-phase handshakes and response pulses.
    initial begin
        bus_exp_t  b;
        resp_exp_t r;
        forever begin
            @(negedge clk);
            if (!rst && ifc.bus_req.valid && ifc.bus_resp.ready) begin
                if (exp_bus.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bus_unexpected: got addr 0x%08h with nothing expected", ifc.bus_req.addr);
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_write", 32'(ifc.bus_req.write), 32'(b.wr));
                    check("bus_addr", ifc.bus_req.addr, b.addr);
                    if (b.wr) begin
                        check("bus_wdata", ifc.bus_req.w_data, b.data);
                        check("bus_strobe", 32'(ifc.bus_req.data_strobe), 32'(b.strb));
                    end else begin
                        n_reads++;
                    end
                end
            end
            if (ifc.resp_valid) begin
                if (exp_resp.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL resp_unexpected: got 0x%08h with nothing expected", ifc.resp_data);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_lane", 32'(ifc.resp_lane), 32'(r.lane));
                    check("resp_data", ifc.resp_data, r.data);
                end
            end
        end
    end

    task automatic drive(input int lane, input bit wr, input logic [1:0] ty, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
        ifc.req_write[lane]        = wr;
        ifc.req_type[lane*2 +: 2]  = ty;
        ifc.req_signed[lane]       = sg;
        ifc.req_addr[lane*32 +: 32]  = a;
        ifc.req_wdata[lane*32 +: 32] = d;
        ifc.req_valid[lane]        = 1'b1;
    endtask

    task automatic wait_accept(input int lane);
        bit got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (ifc.req_ready[lane]) begin
                @(posedge clk);
                #1;
                got = 1;
            end
        end
        ifc.req_valid[lane] = 1'b0;
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: lane %0d never saw ready", lane);
        end
    endtask

    task automatic issue(input int lane, input bit wr, input logic [1:0] ty, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
        drive(lane, wr, ty, sg, a, d);
        wait_accept(lane);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            #1;
            done = ifc.sb_empty && exp_bus.size() == 0 && exp_resp.size() == 0;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: sb_empty %0d, %0d bus and %0d resp pending",
                     ifc.sb_empty, exp_bus.size(), exp_resp.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int lane, input logic [1:0] ty, input bit sg, input logic [31:0] a,
                        input logic [31:0] word, input logic [31:0] exp);
        rd_word = word;
        exp_bus.push_back('{0, {a[31:2], 2'b00}, 32'h0, 4'h0});
        exp_resp.push_back('{lane, exp});
        issue(lane, 1'b0, ty, sg, a, 32'h0);
        wait_idle();
    endtask

    initial begin
        int reads_before;
        rst = 1'b1; addr_en = 1'b1; data_en = 1'b1; rd_word = '0;
        ifc.req_valid = '0; ifc.req_write = '0; ifc.req_type = '0; ifc.req_signed = '0;
        ifc.req_addr = '0; ifc.req_wdata = '0;
        drive(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rst_req_ready", 32'(ifc.req_ready), 32'h0);
        check("rst_resp_valid", 32'(ifc.resp_valid), 32'h0);
        check("rst_resp_data", ifc.resp_data, 32'h0);
        check("rst_resp_lane", 32'(ifc.resp_lane), 32'h0);
        check("rst_sb_empty", 32'(ifc.sb_empty), 32'h1);
        check("rst_bus_req_zero", 32'(ifc.bus_req === '0), 32'h1);
        ifc.req_valid = '0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Word store
        exp_bus.push_back('{1, 32'h1000, 32'hDEADBEEF, 4'hF});
        issue(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF);
        check("sb_busy_after_store", 32'(ifc.sb_empty), 32'h0);
        wait_idle();
        check("sb_empty_after_store", 32'(ifc.sb_empty), 32'h1);

        // Byte and half stores, then loads of each width and sign
        exp_bus.push_back('{1, 32'h1000, 32'h5A000000, 4'b1000});
        issue(0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'h0000005A);
        exp_bus.push_back('{1, 32'h1004, 32'hBEEF0000, 4'b1100});
        issue(0, 1'b1, 2'b01, 1'b0, 32'h1006, 32'h0000BEEF);
        wait_idle();
        load(0, 2'b00, 1'b1, 32'h1003, 32'h85000000, 32'hFFFFFF85);
        load(0, 2'b00, 1'b0, 32'h1003, 32'h85000000, 32'h00000085);
        load(0, 2'b01, 1'b1, 32'h1002, 32'h80017FFF, 32'hFFFF8001);
        load(0, 2'b01, 1'b0, 32'h1000, 32'h80017FFF, 32'h00007FFF);
        load(0, 2'b10, 1'b1, 32'h1000, 32'h80017FFF, 32'h80017FFF);

        // Fill the store buffer while the bus stalls
        addr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_bus.push_back('{1, 32'h3000 + 32'(i*4), 32'(i+1), 4'hF});
            issue(0, 1'b1, 2'b10, 1'b0, 32'h3000 + 32'(i*4), 32'(i+1));
        end
        exp_bus.push_back('{1, 32'h3010, 32'h5, 4'hF});
        drive(0, 1'b1, 2'b10, 1'b0, 32'h3010, 32'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sb_full_ready", 32'(ifc.req_ready), 32'h0);
        end
        check("sb_full_not_empty", 32'(ifc.sb_empty), 32'h0);
        addr_en = 1'b1;
        wait_accept(0);
        wait_idle();

        // Two lanes at once: stores then loads
        exp_bus.push_back('{1, 32'h4000, 32'hA0A0A0A0, 4'hF});
        exp_bus.push_back('{1, 32'h4004, 32'hB1B1B1B1, 4'hF});
        drive(0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'hA0A0A0A0);
        drive(1, 1'b1, 2'b10, 1'b0, 32'h4004, 32'hB1B1B1B1);
        @(negedge clk);
        check("arb_first", 32'(ifc.req_ready), 32'h1);
        @(posedge clk); #1; ifc.req_valid[0] = 1'b0;
        @(negedge clk);
        check("arb_second", 32'(ifc.req_ready), 32'h2);
        @(posedge clk); #1; ifc.req_valid[1] = 1'b0;
        wait_idle();
        rd_word = 32'h000000C3;
        exp_bus.push_back('{0, 32'h5000, 32'h0, 4'h0});
        exp_bus.push_back('{0, 32'h5000, 32'h0, 4'h0});
        exp_resp.push_back('{0, 32'h000000C3});
        exp_resp.push_back('{1, 32'hFFFFFFC3});
        drive(0, 1'b0, 2'b00, 1'b0, 32'h5000, 32'h0);
        drive(1, 1'b0, 2'b00, 1'b1, 32'h5000, 32'h0);
        wait_accept(0);
        @(negedge clk);
        check("load_outstanding_blocks", 32'(ifc.req_ready), 32'h0);
        wait_accept(1);
        wait_idle();

        // Store then load to the same word while the store is still buffered
        addr_en = 1'b0;
        exp_bus.push_back('{1, 32'h2000, 32'h12345678, 4'hF});
        issue(0, 1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678);
`ifdef LSU_STORE_FORWARD_EN
        reads_before = n_reads;
        exp_resp.push_back('{0, 32'h00001234});
        issue(0, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0);
        repeat (3) @(posedge clk);
        addr_en = 1'b1;
        wait_idle();
        check("fwd_no_bus_read", 32'(n_reads), 32'(reads_before));
        addr_en = 1'b0;
        rd_word = 32'hCAFEF00D;
        exp_bus.push_back('{1, 32'h2010, 32'h0000AB00, 4'b0010});
        issue(0, 1'b1, 2'b00, 1'b0, 32'h2011, 32'h000000AB);
        exp_bus.push_back('{0, 32'h2010, 32'h0, 4'h0});
        exp_resp.push_back('{0, 32'hCAFEF00D});
        issue(0, 1'b0, 2'b10, 1'b0, 32'h2010, 32'h0);
        check("partial_fwd_pending", 32'(ifc.sb_empty), 32'h0);
        addr_en = 1'b1;
        wait_idle();
`else
        reads_before = n_reads;
        rd_word = 32'h12345678;
        exp_bus.push_back('{0, 32'h2000, 32'h0, 4'h0});
        exp_resp.push_back('{0, 32'h00001234});
        drive(0, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("load_blocked_by_sb", 32'(ifc.req_ready), 32'h0);
        end
        addr_en = 1'b1;
        wait_accept(0);
        wait_idle();
        check("load_after_drain_reads", 32'(n_reads), 32'(reads_before + 1));
`endif

        // Reset while a store sits in its data phase
        data_en = 1'b0;
        exp_bus.push_back('{1, 32'h6000, 32'h00000077, 4'hF});
        issue(0, 1'b1, 2'b10, 1'b0, 32'h6000, 32'h00000077);
        for (int n = 0; n < 50 && !ifc.bus_req.data_ok; n++) @(negedge clk);
        check("data_phase_reached", 32'(ifc.bus_req.data_ok), 32'h1);
        #1; rst = 1'b1; #1;
        check("rst_mid_valid", 32'(ifc.bus_req.valid), 32'h0);
        check("rst_mid_data_ok", 32'(ifc.bus_req.data_ok), 32'h0);
        check("rst_mid_sb_empty", 32'(ifc.sb_empty), 32'h1);
        check("rst_mid_resp_valid", 32'(ifc.resp_valid), 32'h0);
        @(posedge clk); #1; rst = 1'b0; data_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(ifc.sb_empty), 32'h1);
        check("exp_bus_drained", 32'(exp_bus.size()), 32'h0);
        check("exp_resp_drained", 32'(exp_resp.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
